// File: rtl/count_sequencer.sv
// count_sequencer: start/stop controlled WIDTH-bit event counter with one-shot
// and auto-reload modes, a valid/ready config port and terminal-count ticks.
//
// Optional feature: define CNT_PRESCALE_EN to add the cfg_presc port and a
// prescaler that divides the step rate by (presc_reg + 1).
//
// Handshake: a config transfer happens on any rising edge where
// cfg_valid && cfg_ready. cfg_ready is high in IDLE and DONE and low in RUN.
// The requester holds cfg_valid (and its data) until the transfer edge.
// Start, stop and transfer are all sampled on the same edge. A transfer that
// coincides with start applies to the run being started.
module count_sequencer #(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [WIDTH-1:0]       cfg_period,
  input  logic                   cfg_mode,
  input  logic                   start,
  input  logic                   stop,
  output logic                   busy,
  output logic [WIDTH-1:0]       count,
  output logic                   tick,
  output logic                   done,
  output logic                   err,
`ifdef CNT_PRESCALE_EN
  input  logic [PRESC_WIDTH-1:0] cfg_presc,
`endif
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             step;
  logic             terminal;
  logic [WIDTH-1:0] period_eff;

`ifdef CNT_PRESCALE_EN
  localparam logic [PRESC_WIDTH-1:0] PONE = 1;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
  assign step = (pcnt_q == presc_q);
`else
  // Prescaler width only matters with the prescaler built in.
  if (PRESC_WIDTH < 1) begin : g_presc_width_unused
  end
  assign step = 1'b1;
`endif

  assign cfg_ready  = (state_q != S_RUN);
  assign busy       = (state_q == S_RUN);
  assign xfer       = cfg_valid && cfg_ready;
  // A transfer on the start edge decides whether that start is legal.
  assign period_eff = xfer ? cfg_period : period_q;
  assign terminal   = (count_q == (period_q - ONE));

  assign count     = count_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Next-state, counter, config and pulse decode.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = done_q;
    err_d    = 1'b0;
`ifdef CNT_PRESCALE_EN
    presc_d  = presc_q;
    pcnt_d   = '0;
`endif

    if (xfer) begin
      period_d = cfg_period;
      mode_d   = cfg_mode;
`ifdef CNT_PRESCALE_EN
      presc_d  = cfg_presc;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (period_eff == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            count_d = '0;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
        end else begin
`ifdef CNT_PRESCALE_EN
          pcnt_d = step ? '0 : (pcnt_q + PONE);
`endif
          if (step) begin
            if (terminal) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (!mode_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end else begin
              count_d = count_q + ONE;
            end
          end
        end
      end
      S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else if (start) begin
          if (period_eff == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            count_d = '0;
            done_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CNT_PRESCALE_EN
      presc_q  <= '0;
      pcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef CNT_PRESCALE_EN
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed sequences, a step-count model and a
// per-cycle compare process, plus literal spot checks.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_period = 8'd0;
  logic       cfg_mode = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy;
  logic [7:0] count;
  logic       tick;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;
`ifdef CNT_PRESCALE_EN
  logic [3:0] cfg_presc = 4'd0;
`endif

  int vectors = 0;
  int miscompares = 0;

  count_sequencer #(.WIDTH(8), .PRESC_WIDTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .count      (count),
    .tick       (tick),
    .done       (done),
    .err        (err),
`ifdef CNT_PRESCALE_EN
    .cfg_presc  (cfg_presc),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Check helper
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a run is described by the RUN clocks elapsed since start; the step
  // count is clocks/(presc+1), and the count is steps modulo the period.
  bit m_run = 0, m_done = 0, m_tick = 0, m_err = 0, m_mode = 0;
  int m_period = 0, m_presc = 0, m_clks = 0;

  task automatic model_edge();
    int div;
    int eff_p;
    bit xfer;
    if (!reset_n) begin
      m_run = 0; m_done = 0; m_tick = 0; m_err = 0; m_mode = 0;
      m_period = 0; m_presc = 0; m_clks = 0;
      return;
    end
    div   = m_presc + 1;
    xfer  = cfg_valid && !m_run;
    eff_p = xfer ? int'(cfg_period) : m_period;
    m_tick = 0;
    m_err  = 0;
    if (m_run) begin
      if (stop) begin
        m_run = 0;
      end else begin
        m_clks++;
        if ((m_clks % div == 0) && ((m_clks / div) % m_period == 0)) begin
          m_tick = 1;
          if (!m_mode) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end
    end else begin
      if (xfer) begin
        m_period = int'(cfg_period);
        m_mode   = cfg_mode;
`ifdef CNT_PRESCALE_EN
        m_presc  = int'(cfg_presc);
`endif
      end
      if (stop) begin
        m_done = 0;
      end else if (start) begin
        if (eff_p == 0) begin
          m_err = 1;
        end else begin
          m_run  = 1;
          m_done = 0;
          m_clks = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_edge();
  end

  // Compare process: every falling edge outside reset.
  initial forever begin
    int exp_count;
    @(negedge clk);
    if (reset_n) begin
      exp_count = m_run ? ((m_clks / (m_presc + 1)) % m_period) : 0;
      chk("count", int'(count), exp_count);
      chk("tick", int'(tick), int'(m_tick));
      chk("done", int'(done), int'(m_done));
      chk("err", int'(err), int'(m_err));
      chk("busy", int'(busy), int'(m_run));
      chk("cfg_ready", int'(cfg_ready), int'(!m_run));
    end
  end

  // Drivers
  task automatic do_cfg(input int p, input bit m);
    int n;
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_period = p[7:0];
    cfg_mode   = m;
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("cfg_timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  int nt, nd;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1;

    // Start with period_reg == 0 is rejected
    pulse_start();
    chk("rej_err", int'(err), 1);
    chk("rej_busy", int'(busy), 0);
    @(negedge clk);
    chk("rej_err_pulse", int'(err), 0);

    // One-shot, period 4
    do_cfg(4, 0);
    pulse_start();
    chk("os_busy", int'(busy), 1);
    chk("os_count0", int'(count), 0);
    repeat (3) @(negedge clk);
    chk("os_count3", int'(count), 3);
    chk("os_no_tick", int'(tick), 0);
    @(negedge clk);
    chk("os_tick", int'(tick), 1);
    chk("os_done", int'(done), 1);
    chk("os_idle_busy", int'(busy), 0);
    chk("os_ready", int'(cfg_ready), 1);
    @(negedge clk);
    chk("os_tick_once", int'(tick), 0);
    chk("os_done_level", int'(done), 1);

    // Config in DONE stays in DONE, then auto-reload period 3
    do_cfg(3, 1);
    chk("done_after_cfg", int'(done), 1);
    pulse_start();
    chk("ar_done_cleared", int'(done), 0);
    nt = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick) nt++;
      if (done) nd++;
    end
    chk("ar_ticks", nt, 3);
    chk("ar_never_done", nd, 0);
    pulse_stop();
    chk("ar_stopped", int'(busy), 0);

    // Stop coinciding with terminal count
    do_cfg(5, 1);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("col_count4", int'(count), 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("col_count", int'(count), 0);
    chk("col_tick", int'(tick), 0);
    chk("col_busy", int'(busy), 0);

    // start and stop together in IDLE
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    chk("ss_err", int'(err), 0);

    // Config during RUN is held off until DONE
    do_cfg(3, 0);
    pulse_start();
    cfg_valid = 1'b1; cfg_period = 8'd7; cfg_mode = 1'b1;
    chk("run_cfg_ready", int'(cfg_ready), 0);
    repeat (2) @(negedge clk);
    chk("run_count2", int'(count), 2);
    @(negedge clk);
    chk("run_old_period_tick", int'(tick), 1);
    chk("run_done", int'(done), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("run_cfg_done", int'(done), 1);
    pulse_start();
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("new_period_ticks", nt, 1);
    pulse_stop();

    // Start from DONE after reconfiguring period to 0
    do_cfg(2, 0);
    pulse_start();
    repeat (2) @(negedge clk);
    chk("p2_done", int'(done), 1);
    do_cfg(0, 0);
    pulse_start();
    chk("done_rej_err", int'(err), 1);
    chk("done_rej_done", int'(done), 1);
    pulse_stop();
    chk("done_stop", int'(done), 0);

    // Config on the same edge as start applies to that run
    @(negedge clk);
    cfg_valid = 1'b1; cfg_period = 8'd2; cfg_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    chk("same_edge_busy", int'(busy), 1);
    chk("same_edge_err", int'(err), 0);
    repeat (2) @(negedge clk);
    chk("same_edge_done", int'(done), 1);

    // Asynchronous reset mid-run
    do_cfg(10, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("mid_count5", int'(count), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_ready", int'(cfg_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef CNT_PRESCALE_EN
    // Prescaler: period 2, divisor 4
    cfg_presc = 4'd3;
    do_cfg(2, 1);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("presc_count1", int'(count), 1);
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("presc_ticks", nt, 2);
    pulse_stop();
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
